// File: rtl/jam_pkg.sv
// rtl/jam_pkg.sv - shared widths, state encoding and cost type for the job-assignment engine
package jam_pkg;

  localparam int N_JOBS = 8;
  localparam int COST_W = 7;
  localparam int IDX_W  = 3;
  localparam int ADDR_W = 2 * IDX_W;
  localparam int DEPTH  = N_JOBS * N_JOBS;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    READY = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef logic [COST_W-1:0] cost_t;

  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic parity_bad(input cost_t data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/jam_cost_table_if.sv
// rtl/jam_cost_table_if.sv - load stream and lookup port between the cost table and its users
interface jam_cost_table_if;
  import jam_pkg::*;

  logic             in_valid;
  logic             in_ready;
  cost_t            in_data;
  logic             in_par;
  logic             reload;
  logic [IDX_W-1:0] W;
  logic [IDX_W-1:0] J;
  cost_t            Cost;
  logic             table_ready;
  logic             load_err;

  modport master (
    output in_valid, in_data, in_par, reload, W, J,
    input  in_ready, Cost, table_ready, load_err
  );

  modport slave (
    input  in_valid, in_data, in_par, reload, W, J,
    output in_ready, Cost, table_ready, load_err
  );

endinterface

// File: rtl/jam_cost_mem.sv
// rtl/jam_cost_mem.sv - N*N cost register array, one sync write port, one sync read port
module jam_cost_mem
  import jam_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  cost_t             wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output cost_t             rdata_o
);

  cost_t mem_q [DEPTH];
  cost_t rdata_q;

  // Storage is intentionally not reset so it can become an SRAM macro.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // With re_i low the read register still clocks, but loads zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= re_i ? mem_q[raddr_i] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/jam_cost_table.sv
// rtl/jam_cost_table.sv - cost table load FSM and lookup; JAM_COST_PARITY_EN adds load parity checking
module jam_cost_table
  import jam_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  jam_cost_table_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] lc_q, lc_d;
  logic              err_q, err_d;
  logic              we;
  logic              rd_en;
  logic              in_range;
  logic              word_bad;

`ifdef JAM_COST_PARITY_EN
  assign word_bad = parity_bad(bus.in_data, bus.in_par);
`else
  logic unused_par;
  assign unused_par = bus.in_par;
  assign word_bad   = 1'b0;
`endif

  generate
    if (N_JOBS < (1 << IDX_W)) begin : g_range
      assign in_range = (bus.W < IDX_W'(N_JOBS)) && (bus.J < IDX_W'(N_JOBS));
    end else begin : g_full
      assign in_range = 1'b1;
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= LOAD;
      lc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lc_q    <= lc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    lc_d            = lc_q;
    err_d           = err_q;
    we              = 1'b0;
    rd_en           = 1'b0;
    bus.in_ready    = 1'b0;
    bus.table_ready = 1'b0;
    if (bus.reload) begin
      err_d = 1'b0;
    end
    unique case (state_q)
      LOAD: begin
        bus.in_ready = 1'b1;
        // reload wins over a word presented in the same cycle
        if (bus.reload) begin
          lc_d = '0;
        end else if (bus.in_valid) begin
          we   = 1'b1;
          lc_d = lc_q + ADDR_W'(1);
          if (word_bad) begin
            err_d = 1'b1;
          end
          if (lc_q == ADDR_W'(DEPTH - 1)) begin
            state_d = READY;
            lc_d    = '0;
          end
        end
      end
      READY: begin
        bus.table_ready = 1'b1;
        rd_en           = in_range;
        if (bus.reload) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        state_d = LOAD;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  jam_cost_mem u_mem (
    .clk_i   (CLK),
    .rst_i   (RST),
    .we_i    (we),
    .waddr_i (lc_q),
    .wdata_i (bus.in_data),
    .re_i    (rd_en),
    .raddr_i ({bus.W, bus.J}),
    .rdata_o (bus.Cost)
  );

  assign bus.load_err = err_q;

endmodule

// File: tb/tb_jam_cost_table.sv
// tb/tb_jam_cost_table.sv - self-checking bench for jam_cost_table
module tb_jam_cost_table;
  import jam_pkg::*;

`ifdef JAM_COST_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  jam_cost_table_if bus ();

  jam_cost_table dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    int w;
    int j;
    int exp;
  } vec_t;

  int    errors = 0;
  int    checks = 0;
  cost_t exp_tab [DEPTH];
  int    exp_q [$];
  vec_t  vecs [7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic cost_t word_val(input int mode, input int k);
    case (mode)
      0:       return cost_t'(k % 100);
      1:       return cost_t'(5);
      default: return cost_t'(k + 40);
    endcase
  endfunction

  task automatic load(input int mode, input int gap, input int bad, input int nwords, input bit chk);
    int acc = 0;
    int cyc = 0;
    bit fired;
    bus.W = 3'd1;
    bus.J = 3'd1;
    while (acc < nwords && cyc < 2000) begin
      bus.in_valid = ((cyc % (gap + 1)) == 0);
      bus.in_data  = word_val(mode, acc);
      bus.in_par   = (^bus.in_data) ^ (acc == bad);
      fired = bus.in_valid && bus.in_ready;
      if (fired) exp_tab[acc] = bus.in_data;
      if (chk && nwords == DEPTH && fired && acc == DEPTH - 1)
        check("ready_before_last", int'(bus.table_ready), 0);
      tick;
      if (fired) acc++;
      cyc++;
      if (chk) begin
        check("pre_ready_cost", int'(bus.Cost), 0);
        check("load_err_during_load", int'(bus.load_err), int'(PAR_EN && bad >= 0 && acc > bad));
      end
    end
    bus.in_valid = 1'b0;
    if (acc < nwords) check("load_timeout", acc, nwords);
    if (chk && nwords == DEPTH) begin
      check("ready_edge", int'(bus.table_ready), 1);
      check("in_ready_when_ready", int'(bus.in_ready), 0);
    end
  endtask

  task automatic lookup(input int w, input int j, input int exp, input string name);
    int e;
    bus.W = w[IDX_W-1:0];
    bus.J = j[IDX_W-1:0];
    exp_q.push_back(exp);
    tick;
    e = exp_q.pop_front();
    check(name, int'(bus.Cost), e);
  endtask

  task automatic run_vectors;
    for (int i = 0; i < 7; i++)
      lookup(vecs[i].w, vecs[i].j, vecs[i].exp, $sformatf("lookup_w%0d_j%0d", vecs[i].w, vecs[i].j));
  endtask

  task automatic do_reload;
    bus.reload = 1'b1;
    tick;
    bus.reload = 1'b0;
    check("hold_table_ready", int'(bus.table_ready), 0);
    check("hold_in_ready", int'(bus.in_ready), 0);
    check("reload_clears_err", int'(bus.load_err), 0);
    tick;
    check("after_hold_in_ready", int'(bus.in_ready), 1);
    check("after_hold_cost", int'(bus.Cost), 0);
  endtask

  initial begin
    vecs[0] = '{3, 5, 29};
    vecs[1] = '{7, 7, 63};
    vecs[2] = '{0, 0, 0};
    vecs[3] = '{2, 4, 20};
    vecs[4] = '{7, 0, 56};
    vecs[5] = '{0, 7, 7};
    vecs[6] = '{5, 2, 42};

    RST          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_par   = 1'b0;
    bus.reload   = 1'b0;
    bus.W        = '0;
    bus.J        = '0;
    repeat (3) tick;
    RST = 1'b0;
    tick;
    check("rst_cost", int'(bus.Cost), 0);
    check("rst_table_ready", int'(bus.table_ready), 0);
    check("rst_load_err", int'(bus.load_err), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);

    // ramp load, back-to-back
    load(0, 0, -1, DEPTH, 1'b1);
    run_vectors();

    // writes offered while READY must be ignored
    bus.in_valid = 1'b1;
    bus.in_data  = 7'd127;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("ready_ignores_in_ready", int'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    run_vectors();

    // ramp load with 1-on/2-off gaps
    do_reload();
    load(0, 2, -1, DEPTH, 1'b1);
    run_vectors();

    // reload during load drops the concurrent word, then constant fill
    do_reload();
    load(0, 0, -1, 5, 1'b0);
    bus.reload   = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 7'd77;
    tick;
    bus.reload   = 1'b0;
    bus.in_valid = 1'b0;
    load(1, 0, -1, DEPTH, 1'b1);
    for (int k = 0; k < DEPTH; k++)
      lookup(k / N_JOBS, k % N_JOBS, int'(exp_tab[k]), $sformatf("const5_%0d", k));

    // asynchronous reset from READY
    RST = 1'b1;
    #1;
    check("async_rst_table_ready", int'(bus.table_ready), 0);
    check("async_rst_cost", int'(bus.Cost), 0);
    check("async_rst_in_ready", int'(bus.in_ready), 1);
    RST = 1'b0;
    tick;

    // reset after 20 words, then a full ramp
    load(2, 0, -1, 20, 1'b0);
    RST = 1'b1;
    #1;
    check("midload_rst_in_ready", int'(bus.in_ready), 1);
    check("midload_rst_load_err", int'(bus.load_err), 0);
    tick;
    RST = 1'b0;
    tick;
    load(0, 0, -1, DEPTH, 1'b1);
    run_vectors();

    // parity error on word 10
    do_reload();
    load(0, 0, 10, DEPTH, 1'b1);
    check("err_sticky_at_ready", int'(bus.load_err), int'(PAR_EN));
    run_vectors();
    check("err_sticky_after_lookups", int'(bus.load_err), int'(PAR_EN));
    do_reload();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jam_cost_table.md
# jam_cost_table

Cost-matrix store that sits directly upstream of the job-assignment engine. It loads an N×N table of worker/job costs over a valid/ready stream, then answers the engine's (W, J) lookups with a one-cycle registered Cost. Until loading completes, `table_ready` stays low; the engine is held off on that signal.

## Interface
- `N`, 8, number of workers and jobs (table is N×N; index width `IW` = clog2(N) = 3)
- `COST_W`, 7, cost word width
- `CLK`  in  1  clock, rising edge
- `RST`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  load word present
- `in_ready`  out  1  block accepts a load word this cycle
- `in_data`  in  COST_W  cost word, W-major order (index = W·N + J)
- `in_par`  in  1  even-parity bit over `in_data` (used only with the parity feature)
- `reload`  in  1  single-cycle pulse; discard the table and restart loading
- `W`  in  IW  worker index from the engine
- `J`  in  IW  job index from the engine
- `Cost`  out  COST_W  registered cost for the (W, J) presented in the previous cycle
- `table_ready`  out  1  table is complete; lookups are valid
- `load_err`  out  1  sticky parity error seen during the current load

## Operation
- The state machine has three states: LOAD, READY and HOLD.
- **Reset:**
  - state = LOAD; load counter `lc` = 0.
  - `Cost` = 0, `table_ready` = 0, `load_err` = 0.
  - Table contents are don't-care and are not cleared.
- **LOAD:**
  - `in_ready` = 1.
  - On `in_valid` & `in_ready`, write `in_data` to entry `lc`, then increment `lc`.
  - When the accepted word has `lc` = N²−1, go to READY and clear `lc`.
- **READY:**
  - `in_ready` = 0 and `table_ready` = 1.
  - Each cycle, `Cost` <= table[W·N+J].
  - Any `in_valid` in this state is ignored.
- **HOLD:**
  - Entered from READY on `reload`.
  - Lasts exactly one cycle with `table_ready` = 0 and `in_ready` = 0, then goes to LOAD.
  - This guarantees the engine sees `table_ready` fall before any entry is overwritten.
- **`reload` while in LOAD:**
  - `lc` restarts at 0 and `load_err` is cleared.
  - A word presented in the same cycle is dropped: `reload` takes priority over acceptance.
- **`Cost` outside READY:**
  - `Cost` is forced to 0 in LOAD and HOLD.
  - The lookup register still clocks, but its input is 0.
- **Arithmetic:** the index W·N+J is computed as the concatenation {W, J} when N is a power of two. No other arithmetic is performed; `Cost` is passed through unmodified.
- **Out-of-range indices:** with N < 2^IW, any W or J ≥ N returns 0.

## Timing
- **Lookup latency:** 1 cycle. W/J presented in cycle t appear on `Cost` in cycle t+1. This matches the engine, which drives W/J at count 0..7 and accumulates at count 1..8.
- **Load duration:** minimum N² cycles (64) with `in_valid` held high; gaps in `in_valid` simply stall.
- **Ready edge:** `table_ready` rises in the cycle after the last word is accepted.
- **Reload edge:** `table_ready` falls in the cycle after the `reload` pulse.
- **Reset mid-load:** returns immediately to LOAD with `lc` = 0; all outputs return to their reset values asynchronously.

## Configuration
- **`JAM_COST_PARITY_EN` defined:**
  - Each accepted word is checked: the XOR of `in_data` and `in_par` must be 0.
  - A mismatch sets `load_err` (sticky until reset or `reload`).
  - The word is still stored and loading continues.
  - `table_ready` rises even if `load_err` = 1; the consumer decides what to do.
- **Not defined:** `in_par` is ignored and `load_err` is tied to 0.

## Structure
- **Shared package `jam_pkg`** holds:
  - `N_JOBS` = 8, `COST_W` = 7, `IDX_W` = 3
  - the state enum {LOAD, READY, HOLD}
  - `cost_t` (logic [COST_W−1:0])
- The engine also uses `jam_pkg`, so the widths match by construction.
- **One sub-module, `jam_cost_mem`:** N²×COST_W register array with one synchronous write port and one synchronous read port. It keeps storage separate so it can later be replaced by an SRAM macro.
- The FSM, load counter and parity check remain in the top level.

## Test plan
- **Ramp load:** load entry k = k mod 100 with `in_valid` held high → `table_ready` rises 1 cycle after the 64th handshake. W=3, J=5 → `Cost` = 29 on the next cycle. W=7, J=7 → `Cost` = 63.
- **Backpressure / gaps:**
  - Toggle `in_valid` 1-on/2-off during the load → the same table as the ramp case; `table_ready` only after exactly 64 accepts.
  - `in_valid` during READY → no change to any entry.
- **Reload:**
  - Pulse `reload` in READY → `table_ready` = 0 next cycle, one HOLD cycle, then `in_ready` = 1.
  - Load all entries with 7'd5 → every lookup returns 5.
- **Reset mid-load:** assert `RST` after 20 words, then reload a full ramp → lookup (0,0) = 0 and (2,4) = 20. Confirm no stale data and `lc` restarted at 0.
- **Parity (`JAM_COST_PARITY_EN`):**
  - Word 10 sent with wrong `in_par` → `load_err` = 1 from the following cycle and it stays 1; `table_ready` still rises after word 64.
  - `reload` clears `load_err`.
  - Without the macro → `load_err` stays 0 throughout.
- **Pre-ready lookup:** drive W=1, J=1 during LOAD → `Cost` = 0 every cycle until `table_ready`.
